// File: rtl/snitch_ordered_addr_demux.sv
// Address-decoding request demux for a Snitch data port. Responses return in
// request order by only ever having one output with in-flight transactions.
package snitch_ordered_addr_demux_pkg;
    typedef struct packed {
        logic [31:0] mask;
        logic [31:0] value;
        logic [31:0] slave_idx;
    } addr_rule_t;
endpackage

module snitch_ordered_addr_demux #(
    parameter int  NrOutput       = 2,
    parameter int  AddressWidth   = 32,
    parameter int  NumRules       = 1,
    parameter int  MaxOutstanding = 4,
    parameter int  DefaultIdx     = 0,
    parameter bit  WritesRespond  = 1'b0,
    parameter type req_t          = logic,
    parameter type resp_t         = logic,
    parameter type address_map_t  = snitch_ordered_addr_demux_pkg::addr_rule_t,
    localparam int IdxW           = (NrOutput > 1) ? $clog2(NrOutput) : 1,
    localparam int CntW           = $clog2(MaxOutstanding + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [AddressWidth-1:0] req_addr_i,
    input  logic                    req_write_i,
    input  req_t                    req_payload_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    output resp_t                   resp_payload_o,
    output logic                    resp_valid_o,
    input  logic                    resp_ready_i,
    output req_t                    req_payload_o  [NrOutput],
    output logic [NrOutput-1:0]     req_valid_o,
    input  logic [NrOutput-1:0]     req_ready_i,
    input  resp_t                   resp_payload_i [NrOutput],
    input  logic [NrOutput-1:0]     resp_valid_i,
    output logic [NrOutput-1:0]     resp_ready_o,
    input  address_map_t            address_map_i  [NumRules],
    output logic                    decode_err_o,
    output logic [CntW-1:0]         outstanding_o
);

    logic [CntW-1:0]     r_cnt;
    logic [IdxW-1:0]     r_tgt;
    logic [IdxW-1:0]     w_sel;
    logic                w_match;
    logic                w_uncounted;
    logic                w_busy;
    logic                w_can_issue;
    logic                w_acc;
    logic                w_rsp;
    logic                w_stray;
    logic [NrOutput-1:0] w_tgt_oh;

    // Walk rules from the top down so the lowest matching index wins.
    always_comb begin
        w_sel   = IdxW'(DefaultIdx);
        w_match = 1'b0;
        for (int i = NumRules - 1; i >= 0; i--) begin
            if ((req_addr_i & AddressWidth'(address_map_i[i].mask)) ==
                AddressWidth'(address_map_i[i].value)) begin
                w_sel   = IdxW'(address_map_i[i].slave_idx);
                w_match = 1'b1;
            end
        end
    end

    assign decode_err_o = req_valid_i & ~w_match;
    assign w_uncounted  = req_write_i & ~WritesRespond;
    assign w_busy       = (r_cnt != '0);

    // Only registered state gates issue, keeping resp_* off the req_* path.
    assign w_can_issue = w_uncounted | ~w_busy |
                         ((w_sel == r_tgt) && (r_cnt < CntW'(MaxOutstanding)));

    always_comb begin
        req_valid_o        = '0;
        req_valid_o[w_sel] = req_valid_i & w_can_issue;
    end

    assign req_ready_o = w_can_issue & req_ready_i[w_sel];
    assign w_acc       = req_valid_i & req_ready_o & ~w_uncounted;

    always_comb begin
        for (int k = 0; k < NrOutput; k++) begin
            req_payload_o[k] = req_payload_i;
        end
    end

    always_comb begin
        w_tgt_oh        = '0;
        w_tgt_oh[r_tgt] = w_busy;
    end

    assign resp_valid_o   = |(resp_valid_i & w_tgt_oh);
    assign resp_payload_o = resp_payload_i[r_tgt];
    assign resp_ready_o   = resp_ready_i ? w_tgt_oh : '0;
    assign w_rsp          = resp_valid_o & resp_ready_i;
    assign w_stray        = |(resp_valid_i & ~w_tgt_oh);
    assign outstanding_o  = r_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
            r_tgt <= '0;
        end else begin
            if (w_acc && !w_rsp) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (w_rsp && !w_acc) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_acc) begin
                r_tgt <= w_sel;
            end
        end
    end

`ifndef SYNTHESIS
    a_no_stray_resp: assert property (@(posedge clk_i) disable iff (!rst_ni) !w_stray);
    a_cnt_in_range:  assert property (@(posedge clk_i) disable iff (!rst_ni)
                                      r_cnt <= CntW'(MaxOutstanding));
`endif

endmodule

// File: tb/tb_snitch_ordered_addr_demux.sv
// Scenario bench for snitch_ordered_addr_demux: two outputs, two in flight,
// one rule sending 0x0001_xxxx to output 1 and everything else to output 0.
module tb_snitch_ordered_addr_demux;
    import snitch_ordered_addr_demux_pkg::*;

    localparam logic [31:0] K = 32'h5A5A_0000;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [31:0] req_addr_i;
    logic        req_write_i;
    logic [31:0] req_payload_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [31:0] resp_payload_o;
    logic        resp_valid_o;
    logic        resp_ready_i;
    logic [31:0] req_payload_o [2];
    logic [1:0]  req_valid_o;
    logic [1:0]  req_ready_i;
    logic [31:0] resp_payload_i [2];
    logic [1:0]  resp_valid_i;
    logic [1:0]  resp_ready_o;
    addr_rule_t  amap [1];
    logic        decode_err_o;
    logic [1:0]  outstanding_o;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q [$];
    logic [31:0] exp_v;

    snitch_ordered_addr_demux #(
        .NrOutput(2), .AddressWidth(32), .NumRules(1), .MaxOutstanding(2),
        .DefaultIdx(0), .WritesRespond(1'b0),
        .req_t(logic [31:0]), .resp_t(logic [31:0])
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_addr_i(req_addr_i), .req_write_i(req_write_i), .req_payload_i(req_payload_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .resp_payload_o(resp_payload_o), .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
        .req_payload_o(req_payload_o), .req_valid_o(req_valid_o), .req_ready_i(req_ready_i),
        .resp_payload_i(resp_payload_i), .resp_valid_i(resp_valid_i), .resp_ready_o(resp_ready_o),
        .address_map_i(amap), .decode_err_o(decode_err_o), .outstanding_o(outstanding_o)
    );

    always #5 clk_i = ~clk_i;

    // Scoreboard: accepted reads push the response the bench's downstream
    // model will return; upstream response handshakes pop and compare.
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (req_valid_i && req_ready_o && !req_write_i) exp_q.push_back(req_payload_i ^ K);
            if (resp_valid_o && resp_ready_i) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected_resp: got %h, no response expected", resp_payload_o);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (resp_payload_o !== exp_v) begin
                        n_fail++;
                        $display("FAIL sb_resp_payload: got %h expected %h", resp_payload_o, exp_v);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        req_addr_i    = '0;
        req_write_i   = 1'b0;
        req_payload_i = '0;
        req_valid_i   = 1'b0;
        req_ready_i   = 2'b00;
        resp_valid_i  = 2'b00;
        resp_ready_i  = 1'b0;
        resp_payload_i[0] = 32'hDEAD_0000;
        resp_payload_i[1] = 32'hDEAD_0001;
    endtask

    task automatic drive_req(input logic [31:0] addr, input logic wr, input logic [31:0] pl,
                             input logic [1:0] rdy);
        req_addr_i    = addr;
        req_write_i   = wr;
        req_payload_i = pl;
        req_valid_i   = 1'b1;
        req_ready_i   = rdy;
    endtask

    task automatic drive_resp(input int port, input logic [31:0] pl);
        resp_payload_i[port] = pl ^ K;
        resp_valid_i         = 2'b00;
        resp_valid_i[port]   = 1'b1;
        resp_ready_i         = 1'b1;
    endtask

    task automatic clear_resp();
        resp_valid_i = 2'b00;
        resp_ready_i = 1'b0;
        resp_payload_i[0] = 32'hDEAD_0000;
        resp_payload_i[1] = 32'hDEAD_0001;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        idle();
        resp_ready_i = 1'b1;
        #12;
        n_tests++; if (outstanding_o !== 2'd0) begin n_fail++; $display("FAIL rst_outstanding: got %0d expected 0", outstanding_o); end
        n_tests++; if (resp_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid: got %b expected 0", resp_valid_o); end
        n_tests++; if (resp_ready_o !== 2'b00) begin n_fail++; $display("FAIL rst_resp_ready: got %b expected 00", resp_ready_o); end
        n_tests++; if (req_ready_o !== 1'b0) begin n_fail++; $display("FAIL rst_req_ready_low: got %b expected 0", req_ready_o); end
        req_ready_i = 2'b01;
        #1;
        n_tests++; if (req_ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_req_ready_follow: got %b expected 1", req_ready_o); end
        tick();
        rst_ni = 1'b1;
        idle();
        tick();
    endtask

    task automatic test_read_basic();
        drive_req(32'h0001_0004, 1'b0, 32'h0000_00A1, 2'b10);
        #1;
        n_tests++; if (req_valid_o !== 2'b10) begin n_fail++; $display("FAIL rd_req_valid: got %b expected 10", req_valid_o); end
        n_tests++; if (req_ready_o !== 1'b1) begin n_fail++; $display("FAIL rd_req_ready: got %b expected 1", req_ready_o); end
        n_tests++; if (decode_err_o !== 1'b0) begin n_fail++; $display("FAIL rd_decode_err: got %b expected 0", decode_err_o); end
        n_tests++; if (req_payload_o[0] !== 32'hA1 || req_payload_o[1] !== 32'hA1) begin n_fail++; $display("FAIL rd_payload_bcast: got %h/%h expected a1", req_payload_o[0], req_payload_o[1]); end
        tick();
        idle();
        n_tests++; if (outstanding_o !== 2'd1) begin n_fail++; $display("FAIL rd_outstanding_1: got %0d expected 1", outstanding_o); end
        drive_resp(1, 32'h0000_00A1);
        #1;
        n_tests++; if (resp_valid_o !== 1'b1) begin n_fail++; $display("FAIL rd_resp_valid: got %b expected 1", resp_valid_o); end
        n_tests++; if (resp_ready_o !== 2'b10) begin n_fail++; $display("FAIL rd_resp_ready: got %b expected 10", resp_ready_o); end
        tick();
        clear_resp();
        n_tests++; if (outstanding_o !== 2'd0) begin n_fail++; $display("FAIL rd_outstanding_0: got %0d expected 0", outstanding_o); end
    endtask

    task automatic test_full();
        drive_req(32'h0001_0000, 1'b0, 32'h0000_0001, 2'b10);
        #1;
        n_tests++; if (req_ready_o !== 1'b1) begin n_fail++; $display("FAIL full_rd1_ready: got %b expected 1", req_ready_o); end
        tick();
        req_payload_i = 32'h0000_0002;
        #1;
        n_tests++; if (req_ready_o !== 1'b1 || outstanding_o !== 2'd1) begin n_fail++; $display("FAIL full_rd2: ready %b cnt %0d expected ready 1 cnt 1", req_ready_o, outstanding_o); end
        tick();
        req_payload_i = 32'h0000_0003;
        #1;
        n_tests++; if (outstanding_o !== 2'd2) begin n_fail++; $display("FAIL full_cnt_2: got %0d expected 2", outstanding_o); end
        n_tests++; if (req_ready_o !== 1'b0 || req_valid_o !== 2'b00) begin n_fail++; $display("FAIL full_stall: ready %b valid %b expected 0/00", req_ready_o, req_valid_o); end
        tick();
        drive_resp(1, 32'h0000_0001);
        #1;
        n_tests++; if (req_ready_o !== 1'b0) begin n_fail++; $display("FAIL full_same_cycle_resp: got %b expected 0", req_ready_o); end
        tick();
        clear_resp();
        #1;
        n_tests++; if (req_ready_o !== 1'b1 || outstanding_o !== 2'd1) begin n_fail++; $display("FAIL full_unblock: ready %b cnt %0d expected ready 1 cnt 1", req_ready_o, outstanding_o); end
        tick();
        idle();
        n_tests++; if (outstanding_o !== 2'd2) begin n_fail++; $display("FAIL full_rd3_counted: got %0d expected 2", outstanding_o); end
        for (int i = 2; i <= 3; i++) begin
            drive_resp(1, 32'(i));
            tick();
            clear_resp();
        end
        n_tests++; if (outstanding_o !== 2'd0) begin n_fail++; $display("FAIL full_drained: got %0d expected 0", outstanding_o); end
    endtask

    task automatic test_target_switch();
        drive_req(32'h0001_0008, 1'b0, 32'h0000_0010, 2'b10);
        tick();
        drive_req(32'h0000_1000, 1'b0, 32'h0000_0011, 2'b11);
        #1;
        n_tests++; if (req_ready_o !== 1'b0 || req_valid_o !== 2'b00) begin n_fail++; $display("FAIL sw_blocked: ready %b valid %b expected 0/00", req_ready_o, req_valid_o); end
        tick();
        drive_resp(1, 32'h0000_0010);
        #1;
        n_tests++; if (req_ready_o !== 1'b0 || req_valid_o !== 2'b00) begin n_fail++; $display("FAIL sw_drain_cycle: ready %b valid %b expected 0/00", req_ready_o, req_valid_o); end
        tick();
        clear_resp();
        #1;
        n_tests++; if (req_ready_o !== 1'b1 || req_valid_o !== 2'b01) begin n_fail++; $display("FAIL sw_issue: ready %b valid %b expected 1/01", req_ready_o, req_valid_o); end
        tick();
        idle();
        drive_resp(0, 32'h0000_0011);
        #1;
        n_tests++; if (resp_ready_o !== 2'b01) begin n_fail++; $display("FAIL sw_resp_port0: got %b expected 01", resp_ready_o); end
        tick();
        clear_resp();
    endtask

    task automatic test_decode_err();
        drive_req(32'h8000_0000, 1'b0, 32'h0000_0020, 2'b01);
        #1;
        n_tests++; if (decode_err_o !== 1'b1) begin n_fail++; $display("FAIL de_flag: got %b expected 1", decode_err_o); end
        n_tests++; if (req_valid_o !== 2'b01 || req_ready_o !== 1'b1) begin n_fail++; $display("FAIL de_route: valid %b ready %b expected 01/1", req_valid_o, req_ready_o); end
        tick();
        idle();
        #1;
        n_tests++; if (decode_err_o !== 1'b0) begin n_fail++; $display("FAIL de_idle: got %b expected 0", decode_err_o); end
        drive_resp(0, 32'h0000_0020);
        tick();
        clear_resp();
    endtask

    task automatic test_uncounted_write();
        drive_req(32'h0001_0040, 1'b0, 32'h0000_0030, 2'b10);
        tick();
        drive_req(32'h0000_0010, 1'b1, 32'h0000_0031, 2'b11);
        #1;
        n_tests++; if (req_ready_o !== 1'b1 || req_valid_o !== 2'b01) begin n_fail++; $display("FAIL wr_issue: ready %b valid %b expected 1/01", req_ready_o, req_valid_o); end
        tick();
        idle();
        n_tests++; if (outstanding_o !== 2'd1) begin n_fail++; $display("FAIL wr_not_counted: got %0d expected 1", outstanding_o); end
        drive_resp(1, 32'h0000_0030);
        tick();
        clear_resp();
    endtask

    task automatic test_async_reset();
        drive_req(32'h0001_0000, 1'b0, 32'h0000_0040, 2'b10);
        tick();
        req_payload_i = 32'h0000_0041;
        tick();
        idle();
        n_tests++; if (outstanding_o !== 2'd2) begin n_fail++; $display("FAIL ar_cnt_before: got %0d expected 2", outstanding_o); end
        #2;
        rst_ni = 1'b0;
        #1;
        n_tests++; if (outstanding_o !== 2'd0) begin n_fail++; $display("FAIL ar_async_clear: got %0d expected 0", outstanding_o); end
        exp_q.delete();
        tick();
        rst_ni = 1'b1;
        drive_req(32'h0000_2000, 1'b0, 32'h0000_0042, 2'b01);
        #1;
        n_tests++; if (req_ready_o !== 1'b1 || req_valid_o !== 2'b01) begin n_fail++; $display("FAIL ar_issue_after: ready %b valid %b expected 1/01", req_ready_o, req_valid_o); end
        tick();
        idle();
        drive_resp(0, 32'h0000_0042);
        tick();
        clear_resp();
        n_tests++; if (outstanding_o !== 2'd0) begin n_fail++; $display("FAIL ar_final_cnt: got %0d expected 0", outstanding_o); end
    endtask

    initial begin
        amap[0] = '{mask: 32'hFFFF_0000, value: 32'h0001_0000, slave_idx: 32'd1};
        test_reset();
        test_read_basic();
        test_full();
        test_target_switch();
        test_decode_err();
        test_uncounted_write();
        test_async_reset();
        tick();
        n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL sb_leftover: got %0d pending expected 0", exp_q.size()); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/snitch_ordered_addr_demux.md
# snitch_ordered_addr_demux

Address-decoding request demultiplexer for a Snitch core port that routes each request to one of `NrOutput` downstream interconnects. Responses come back in request order without a response arbiter. The block tracks the number of outstanding response-bearing transactions and the output they target. It stalls a request to a different output until all responses from the current output have drained, and caps in-flight transactions at `MaxOutstanding`. It sits between the core's data port and the TCDM/AXI/peripheral interconnects.

## Interface
- `NrOutput`, 2: number of downstream outputs (≥1).
- `AddressWidth`, 32: request address width.
- `NumRules`, 1: number of entries in `address_map_i`.
- `MaxOutstanding`, 4: maximum in-flight response-bearing transactions (≥1).
- `DefaultIdx`, 0: output used when no rule matches.
- `WritesRespond`, 1'b0: 1 = writes return a response and are counted; 0 = writes are fire-and-forget.
- `req_t` / `resp_t`, logic: payload types.
- Ports, in order:
  - `clk_i` in 1: clock.
  - `rst_ni` in 1: asynchronous active-low reset.
  - `req_addr_i` in `AddressWidth`: request address.
  - `req_write_i` in 1: request is a write.
  - `req_payload_i` in `req_t`: request payload.
  - `req_valid_i` in 1 / `req_ready_o` out 1: upstream request handshake.
  - `resp_payload_o` out `resp_t`; `resp_valid_o` out 1 / `resp_ready_i` in 1: upstream response.
  - `req_payload_o` out `NrOutput`×`req_t`: payload broadcast to every output.
  - `req_valid_o` out `NrOutput` / `req_ready_i` in `NrOutput`: downstream requests.
  - `resp_payload_i` in `NrOutput`×`resp_t`; `resp_valid_i` in `NrOutput` / `resp_ready_o` out `NrOutput`: downstream responses.
  - `address_map_i` in `NumRules`×`address_map_t`: rules with `mask`, `value` and `slave_idx`.
  - `decode_err_o` out 1: no rule matched the current valid request.
  - `outstanding_o` out `$clog2(MaxOutstanding+1)`: current in-flight count.

## Operation
- **Decode:** `match[i] = (req_addr_i & mask[i]) == value[i]`. The lowest matching index wins and `sel = slave_idx` of that rule. With no match, `sel = DefaultIdx` and `decode_err_o = req_valid_i`.
- **State:**
  - `cnt`: in-flight count, 0..`MaxOutstanding`.
  - `tgt`: output owning the in-flight transactions.
- **Issue condition:** `can_issue = (cnt == 0) | (sel == tgt & cnt < MaxOutstanding)`. It uses registered state only; there is no combinational path from `resp_*` to `req_*`.
- **Request path:**
  - `req_valid_o[sel] = req_valid_i & can_issue`; all other bits are 0.
  - `req_ready_o = can_issue & req_ready_i[sel]`.
  - `req_payload_o[k] = req_payload_i` for all k.
- **Counted request:** `acc = req_valid_i & req_ready_o & (!req_write_i | WritesRespond)`.
- **Response path:**
  - `resp_valid_o = resp_valid_i[tgt] & (cnt != 0)`.
  - `resp_payload_o = resp_payload_i[tgt]`.
  - `resp_ready_o[tgt] = resp_ready_i & (cnt != 0)`; all other bits are 0.
  - `rsp` = upstream response handshake.
- **Counter update:**
  - `acc & !rsp`: cnt+1.
  - `rsp & !acc`: cnt−1.
  - Both or neither: unchanged.
- **Target update:** on `acc`, `tgt <= sel`. This is a no-op when `cnt != 0`, because `can_issue` forces `sel == tgt`.
- **Uncounted requests:** a non-counted write (`WritesRespond = 0`) is always issuable to any output, including while `cnt != 0`. It leaves `cnt` and `tgt` untouched and is therefore subject only to `req_ready_i[sel]`. Formally, for `req_write_i & !WritesRespond`, `can_issue` is 1.
- **Stray responses:** a response on an output `≠ tgt`, or any response while `cnt == 0`, is a protocol violation. The block never acknowledges it, and a simulation assertion flags it.

## Timing
- **Reset:**
  - State: `cnt = 0`, `tgt = 0`.
  - Outputs: `outstanding_o = 0`; `req_ready_o = 0` unless `req_ready_i[sel]`; `resp_valid_o = 0`; `resp_ready_o = 0`.
  - Asynchronous reset mid-operation drops all in-flight tracking immediately.
- **Latency:** zero added cycles on both request and response paths (purely combinational forwarding). The state updates at the next `clk_i` edge.
- **Target switch:** the cycle in which the last response drains (cnt 1→0) still blocks a different-target request. It issues at the earliest in the next cycle, so the switch costs ≥1 bubble.
- **Full:** at `cnt == MaxOutstanding`, same-target requests stall. A simultaneous response in that cycle does not unblock them until the next cycle.
- **Overflow:** the counter never exceeds `MaxOutstanding` and never underflows. An assertion checks both.
- **Stability:** `req_valid_o` may deassert only if `req_valid_i` drops; upstream must hold valid until ready.

## Test plan
Common configuration: `NrOutput = 2`, `MaxOutstanding = 2`, rule0 `mask = 0xFFFF_0000`, `value = 0x0001_0000`, `idx = 1`, `DefaultIdx = 0`.

1. Read to `0x0001_0004`, with `req_ready_i[1] = 1` → same cycle `req_valid_o = 2'b10`; next cycle `outstanding_o = 1`; response on port 1 forwarded, with `resp_ready_o = 2'b10` and then `outstanding_o = 0`.
2. Three reads to `0x0001_0000`, downstream never responding → the first two are accepted and the third shows `req_ready_o = 0` at `outstanding_o = 2`. One response is returned → the third is accepted the following cycle.
3. Read to port 1 outstanding, then a read to `0x0000_1000` (port 0) → `req_ready_o = 0` and `req_valid_o = 0` until the port-1 response completes. The port-0 request issues exactly one cycle later.
4. Read to `0x8000_0000` → `decode_err_o = 1` and the request is routed to port 0 (`req_valid_o = 2'b01`).
5. With `WritesRespond = 0` and a read pending on port 1 → a write to port 0 is accepted immediately and `outstanding_o` stays 1.
6. `rst_ni` asserted while `cnt = 2` → `outstanding_o = 0` asynchronously; after release, a read to port 0 issues without stall.
